pipeline_cg_ctrl: RTL
=====================

// Module: pipeline_cg_ctrl
// PURPOSE
//  Central stall/flush/sleep sequencer for the 4 clock-gated pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
//  Drives each register's clock-gate enable, tracks per-stage valid bits, and inserts bubbles on hazards.
//  Gates clocks of registers whose content would not change, and puts the whole pipeline to sleep on halt or idle timeout.
// PARAMETERS
//  IDLE_CYCLES  16                         consecutive cycles with fetch_valid=0 and pipeline empty before auto-sleep; 0 disables auto-sleep
//  CNT_W        $clog2(IDLE_CYCLES+1)      idle counter width (derived, not overridden)
// PORTS
//  clk          in   1  single clock; all state on posedge clk
//  rst_n        in   1  synchronous, active-low reset
//  fetch_valid  in   1  IF has a valid instruction this cycle
//  load_use     in   1  ID instruction depends on load in EX
//  branch_taken in   1  EX resolved a taken branch/jump
//  mem_busy     in   1  MEM stage multi-cycle access in progress
//  halt_req     in   1  drain pipeline and sleep (level, sampled in RUN)
//  wake_req     in   1  leave SLEEP
//  en_pc        out  1  PC register clock enable
//  en_stage     out  4  clock enables [0]=IF/ID [1]=ID/EX [2]=EX/MEM [3]=MEM/WB
//  stage_valid  out  4  registered valid bits, same index order
//  sleeping     out  1  1 while in SLEEP
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=RUN, stage_valid=4'b0000, idle_cnt=0, sleeping=0.
//   Combinational outputs en_pc and en_stage are 0 while rst_n=0.
//  FSM (pipe_state_e): RUN, DRAIN, SLEEP, WAKE.
//   RUN   -> DRAIN if halt_req=1.
//   RUN   -> SLEEP if IDLE_CYCLES!=0, idle_cnt==IDLE_CYCLES, and stage_valid==0.
//   DRAIN -> SLEEP when stage_valid==0.
//   SLEEP -> WAKE on wake_req=1.
//   WAKE  -> RUN after exactly 1 cycle.
//   halt_req in WAKE is ignored until RUN.
//  Advance rule in RUN (priority high to low):
//   mem_busy:     all en_*=0; valid[3] <= 0 (bubble into WB); valid[2:0] hold.
//   branch_taken: en_pc=1; valid[0] <= 0; valid[1] <= 0; valid[2] <= valid[1] (the branch itself); valid[3] <= valid[2].
//   load_use:     en_pc=0; IF/ID holds; valid[1] <= 0 (bubble); valid[3:2] <= valid[2:1].
//   otherwise:    en_pc=1; valid[0] <= fetch_valid; valid[i] <= valid[i-1].
//  Gating rule, applied after the advance rule:
//   en_stage[i] = advancing_i & (incoming_valid_i | stage_valid[i]).
//   A bubble replacing a bubble is never clocked; a held stage is never clocked.
//   incoming_valid_0 = fetch_valid.
//  DRAIN: en_pc=0; valid[0] <= 0 each cycle; downstream advances as in RUN.
//   mem_busy still freezes in DRAIN. branch_taken in DRAIN squashes as in RUN, but en_pc=0.
//  SLEEP: en_pc=0, en_stage=0, valid=0, sleeping=1. All hazard inputs are ignored.
//  WAKE: en_pc=1, en_stage=0, sleeping=0. The first fetch is sampled in the following RUN cycle.
//  Idle counter:
//   Counts in RUN while fetch_valid=0 and stage_valid==0; saturates at IDLE_CYCLES.
//   Clears on any fetch_valid=1, any stage valid, or leaving RUN.
//  Simultaneous events:
//   mem_busy masks branch_taken and load_use that cycle (EX is frozen, so both inputs re-assert).
//   branch_taken with load_use: branch wins.
//   halt_req with a hazard: the hazard action applies this cycle, and state moves to DRAIN.
//  Reset mid-operation (any state): next cycle is the reset state; in-flight valid bits are discarded.
// STRUCTURE
//  pipe_ctrl_pkg:
//   typedef enum logic [1:0] pipe_state_e {RUN, DRAIN, SLEEP, WAKE};
//   localparam STG_IFID=0, STG_IDEX=1, STG_EXMEM=2, STG_MEMWB=3; NUM_STG=4.
//  Sub-module idle_timer #(IDLE_CYCLES): saturating counter with clear/inc inputs and a sat output.
//  Remaining logic (FSM, valid shift, enable decode) is inline.
// TESTING
//  1 Reset then fetch_valid=1 x4 -> stage_valid 0001, 0011, 0111, 1111; en_stage=1111 on cycle 4; en_pc=1 throughout.
//  2 Full pipe, load_use=1 for 1 cycle -> en_pc=0, en_stage=4'b1110, stage_valid next = 4'b1101; the ID instruction is retained.
//  3 Full pipe, branch_taken=1 and load_use=1 together -> en_pc=1, stage_valid next = 4'b1100.
//  4 Full pipe, mem_busy=1 for 3 cycles -> en_pc=0, en_stage=0000 each cycle; stage_valid 0111 held; then resumes normal shift.
//  5 halt_req=1 with 1111 -> DRAIN; valid 1110, 1100, 1000, 0000; SLEEP next cycle, sleeping=1.
//    wake_req=1 -> WAKE for 1 cycle (en_pc=1) -> RUN.
//  6 IDLE_CYCLES=4, empty pipe, fetch_valid=0 -> sleeping=1 after 5 cycles.
//    A fetch_valid pulse at cycle 3 restarts the count.
//    rst_n=0 while in SLEEP -> RUN, sleeping=0 next cycle.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and stage indices for the pipeline clock-gate controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    SLEEP = 2'd2,
    WAKE  = 2'd3
  } pipe_state_e;

  localparam int unsigned STG_IFID  = 0;
  localparam int unsigned STG_IDEX  = 1;
  localparam int unsigned STG_EXMEM = 2;
  localparam int unsigned STG_MEMWB = 3;
  localparam int unsigned NUM_STG   = 4;

endpackage

// File: rtl/idle_timer.sv
// Saturating idle counter; sat_o flags IDLE_CYCLES consecutive idle cycles.
module idle_timer #(
  parameter int unsigned IDLE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic sat_o
);

  // A zero-length count would be illegal, so the disabled case keeps one bit.
  localparam int unsigned CNT_W = (IDLE_CYCLES > 0) ? $clog2(IDLE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(IDLE_CYCLES);

  logic [CNT_W-1:0] cnt_q;
  logic             at_max;

  assign at_max = (cnt_q == CNT_MAX);
  assign sat_o  = (IDLE_CYCLES != 0) && at_max;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && !at_max) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipeline_cg_ctrl.sv
// Stall/flush/sleep sequencer: drives PC and pipeline-register clock gates and tracks stage valids.
module pipeline_cg_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned IDLE_CYCLES = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         fetch_valid,
  input  logic         load_use,
  input  logic         branch_taken,
  input  logic         mem_busy,
  input  logic         halt_req,
  input  logic         wake_req,
  output logic         en_pc,
  output logic [3:0]   en_stage,
  output logic [3:0]   stage_valid,
  output logic         sleeping
);

  pipe_state_e        state_q, state_d;
  logic [NUM_STG-1:0] valid_q, valid_d;
  logic [NUM_STG-1:0] adv;
  logic [NUM_STG-1:0] en_stage_c;
  logic               en_pc_c;
  logic               sleeping_q;
  logic               idle_inc;
  logic               idle_sat;

  idle_timer #(
    .IDLE_CYCLES (IDLE_CYCLES)
  ) u_idle_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (!idle_inc),
    .inc_i (idle_inc),
    .sat_o (idle_sat)
  );

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    adv     = '0;
    en_pc_c = 1'b0;

    unique case (state_q)
      RUN, DRAIN: begin
        if (mem_busy) begin
          valid_d[STG_MEMWB] = 1'b0;
        end else if (branch_taken) begin
          adv                = '1;
          valid_d[STG_IFID]  = 1'b0;
          valid_d[STG_IDEX]  = 1'b0;
          valid_d[STG_EXMEM] = valid_q[STG_IDEX];
          valid_d[STG_MEMWB] = valid_q[STG_EXMEM];
          en_pc_c            = (state_q == RUN);
        end else if (load_use) begin
          adv                = '1;
          adv[STG_IFID]      = 1'b0;
          valid_d[STG_IDEX]  = 1'b0;
          valid_d[STG_EXMEM] = valid_q[STG_IDEX];
          valid_d[STG_MEMWB] = valid_q[STG_EXMEM];
        end else begin
          adv                = '1;
          valid_d            = {valid_q[NUM_STG-2:0], fetch_valid};
          en_pc_c            = (state_q == RUN);
        end
        // While draining, IF/ID is flushed every unfrozen cycle regardless of the hazard.
        if (state_q == DRAIN && !mem_busy) begin
          adv[STG_IFID]     = 1'b1;
          valid_d[STG_IFID] = 1'b0;
        end

        if (state_q == RUN) begin
          if (halt_req) begin
            state_d = DRAIN;
          end else if (idle_sat && valid_q == '0) begin
            state_d = SLEEP;
          end
        end else if (valid_q == '0) begin
          state_d = SLEEP;
        end
      end
      SLEEP: begin
        valid_d = '0;
        if (wake_req) begin
          state_d = WAKE;
        end
      end
      WAKE: begin
        en_pc_c = 1'b1;
        state_d = RUN;
      end
    endcase

    en_stage_c = adv & (valid_d | valid_q);
  end

  assign idle_inc = (state_q == RUN) && (state_d == RUN) && !fetch_valid && (valid_q == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= RUN;
      valid_q    <= '0;
      sleeping_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      sleeping_q <= (state_d == SLEEP);
    end
  end

  assign en_pc       = rst_n & en_pc_c;
  assign en_stage    = {NUM_STG{rst_n}} & en_stage_c;
  assign stage_valid = valid_q;
  assign sleeping    = sleeping_q;

endmodule
